// File: rtl/regbank_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: field widths,
// FSM state encodings and requester identifiers.
package regbank_write_arbiter_pkg;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_A = 2'd1,
      ST_OWN_B = 2'd2
   } state_e;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_e;

endpackage

// File: rtl/regbank_write_arbiter_onehot_dec.sv
// One-hot decoder of a register index into NREG selects; oor_o flags an
// index with no matching register.
module onehot_dec
   import regbank_write_arbiter_pkg::*;
#(
   parameter int NREG = 8
) (
   input  logic [ADDR_W-1:0] idx_i,
   output logic [NREG-1:0]   onehot_o,
   output logic              oor_o
);

   always_comb begin
      onehot_o = '0;
      oor_o    = 1'b1;
      for (int i = 0; i < NREG; i++) begin
         if (idx_i == ADDR_W'(i)) begin
            onehot_o[i] = 1'b1;
            oor_o       = 1'b0;
         end
      end
   end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Two-source round-robin write-port arbiter with optional burst locking,
// driving a register bank through a registered select/enable/data stage.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | port free; grant by single request or prio_q on contention
// ST_OWN_A | A holds the port for a locked burst; B waits
// ST_OWN_B | B holds the port for a locked burst; A waits
module regbank_write_arbiter
   import regbank_write_arbiter_pkg::*;
#(
   parameter int NREG      = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_a_i,
   input  logic              req_b_i,
   input  logic              lock_a_i,
   input  logic              lock_b_i,
   input  logic [ADDR_W-1:0] addr_a_i,
   input  logic [ADDR_W-1:0] addr_b_i,
   input  logic [DATA_W-1:0] data_a_i,
   input  logic [DATA_W-1:0] data_b_i,
   output logic              gnt_a_o,
   output logic              gnt_b_o,
   output logic [NREG-1:0]   chosen_o,
   output logic              w_en_o,
   output logic [DATA_W-1:0] w_data_o,
   output logic              err_o
);

   localparam int             CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

   state_e              state_q;
   src_e                prio_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [NREG-1:0]     chosen_q;
   logic                w_en_q;
   logic [DATA_W-1:0]   w_data_q;
   logic                err_q;

   logic                xfer_a, xfer_b, xfer;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;
   logic                sel_lock;
   logic [NREG-1:0]     dec_onehot;
   logic                dec_oor;
   logic                wr_ok;
   logic [CNT_W-1:0]    cnt_inc;
   logic                release_port;

   always_comb begin
      gnt_a_o = 1'b0;
      gnt_b_o = 1'b0;
      if (rst_ni) begin
         case (state_q)
            ST_OWN_A: gnt_a_o = req_a_i;
            ST_OWN_B: gnt_b_o = req_b_i;
            default: begin
               if (req_a_i && req_b_i) begin
                  gnt_a_o = (prio_q == SRC_A);
                  gnt_b_o = (prio_q == SRC_B);
               end else begin
                  gnt_a_o = req_a_i;
                  gnt_b_o = req_b_i;
               end
            end
         endcase
      end
   end

   assign xfer_a   = req_a_i & gnt_a_o;
   assign xfer_b   = req_b_i & gnt_b_o;
   assign xfer     = xfer_a | xfer_b;
   assign sel_addr = xfer_b ? addr_b_i : addr_a_i;
   assign sel_data = xfer_b ? data_b_i : data_a_i;
   assign sel_lock = xfer_b ? lock_b_i : lock_a_i;
   assign wr_ok    = xfer & ~dec_oor;

   // cnt_q is 0 in IDLE, so a single rule covers both entering and extending
   // a burst; with MAX_BURST=1 every locked transfer is an immediate release.
   assign cnt_inc      = cnt_q + 1'b1;
   assign release_port = ~sel_lock | (cnt_inc == CNT_MAX);

   onehot_dec #(.NREG(NREG)) u_dec (
      .idx_i    (sel_addr),
      .onehot_o (dec_onehot),
      .oor_o    (dec_oor)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         prio_q   <= SRC_A;
         cnt_q    <= '0;
         chosen_q <= '0;
         w_en_q   <= 1'b0;
         w_data_q <= '0;
         err_q    <= 1'b0;
      end else begin
         w_en_q   <= wr_ok;
         chosen_q <= {NREG{wr_ok}} & dec_onehot;
         if (wr_ok) w_data_q <= sel_data;
         if (xfer && dec_oor) err_q <= 1'b1;

         case (state_q)
            ST_IDLE: begin
               if (xfer) begin
                  prio_q <= xfer_b ? SRC_A : SRC_B;
                  if (release_port) begin
                     cnt_q <= '0;
                  end else begin
                     state_q <= xfer_b ? ST_OWN_B : ST_OWN_A;
                     cnt_q   <= cnt_inc;
                  end
               end
            end
            ST_OWN_A: begin
               if (!req_a_i || release_port) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  prio_q  <= SRC_B;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            ST_OWN_B: begin
               if (!req_b_i || release_port) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  prio_q  <= SRC_A;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign chosen_o = chosen_q;
   assign w_en_o   = w_en_q;
   assign w_data_o = w_data_q;
   assign err_o    = err_q;

endmodule
